// File: rtl/calc_result_display.sv
// calc_result_display
// Captures the calculator result on a rising edge of Done, converts it to
// five BCD digits with a one-shift-per-clock double-dabble engine, and scans
// the result onto an 8-digit multiplexed active-low seven-segment display.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no result since reset; display blank, waiting for a trigger
// CONVERT | double-dabble in progress, 16 shift cycles, triggers dropped
// HOLD    | conversion complete; Digits/display valid until next trigger

module calc_result_display #(
    parameter int REFRESH_BITS = 18
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Done,
    input  logic [15:0] C,
    input  logic        Flag,
    output logic [19:0] Digits,
    output logic        Valid,
    output logic        Busy,
    output logic [7:0]  An,
    output logic [6:0]  Ssd,
    output logic        Dp
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_HOLD    = 2'd2
    } state_t;

    state_t r_state;
    state_t w_state_next;

    logic                    r_done_q;
    logic [15:0]             r_bin;
    logic [19:0]             r_bcd;
    logic [3:0]              r_cnt;
    logic                    r_flag;
    logic [19:0]             r_digits;
    logic                    r_valid;
    logic                    r_busy;
    logic [REFRESH_BITS-1:0] r_refresh;
    logic [7:0]              r_an;
    logic [6:0]              r_ssd;

    logic        w_trigger;
    logic        w_capture;
    logic        w_finish;
    logic [19:0] w_bcd_adj;
    logic [19:0] w_bcd_next;
    logic [15:0] w_bin_next;
    logic [2:0]  w_sel;
    logic [4:0]  w_nz;
    logic        w_show;
    logic [3:0]  w_code;
    logic [7:0]  w_an_next;
    logic [6:0]  w_ssd_next;

    // Active-low segment pattern {a,b,c,d,e,f,g} for a digit code; 4'hF is "F".
    function automatic logic [6:0] seg_encode(input logic [3:0] code);
        logic [6:0] s;
        case (code)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            4'hF:    s = 7'b0111000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    // Only a low-to-high transition of Done starts a conversion.
    assign w_trigger = Done & ~r_done_q;

    // Double-dabble step: correct every nibble >= 5, then shift {bcd,bin} left.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_next = {w_bcd_adj[18:0], r_bin[15]};
        w_bin_next = {r_bin[14:0], 1'b0};
    end

    // State register.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; triggers arriving mid-conversion are simply ignored.
    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE, S_HOLD: begin
                if (w_trigger) begin
                    w_state_next = S_CONVERT;
                    w_capture    = 1'b1;
                end
            end
            S_CONVERT: begin
                if (r_cnt == 4'd15) begin
                    w_state_next = S_HOLD;
                    w_finish     = 1'b1;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Capture, shift engine and result/status registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_done_q <= 1'b0;
            r_bin    <= '0;
            r_bcd    <= '0;
            r_cnt    <= '0;
            r_flag   <= 1'b0;
            r_digits <= '0;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done_q <= Done;
            if (w_capture) begin
                r_bin   <= C;
                r_flag  <= Flag;
                r_bcd   <= '0;
                r_cnt   <= '0;
                r_valid <= 1'b0;
                r_busy  <= 1'b1;
            end else if (r_state == S_CONVERT) begin
                r_bcd <= w_bcd_next;
                r_bin <= w_bin_next;
                r_cnt <= r_cnt + 4'd1;
                if (w_finish) begin
                    r_digits <= w_bcd_next;
                    r_valid  <= 1'b1;
                    r_busy   <= 1'b0;
                end
            end
        end
    end

    // Free-running refresh counter; its top three bits pick the scanned digit.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_refresh <= '0;
        end else begin
            r_refresh <= r_refresh + {{(REFRESH_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign w_sel = r_refresh[REFRESH_BITS-1 -: 3];

    // A digit above d0 is lit only if it or some more significant digit is nonzero.
    assign w_nz[0] = 1'b1;
    assign w_nz[1] = |r_digits[19:4];
    assign w_nz[2] = |r_digits[19:8];
    assign w_nz[3] = |r_digits[19:12];
    assign w_nz[4] = |r_digits[19:16];

    // Select the scanned digit, apply blanking, and form anode/segment values.
    always_comb begin
        w_show     = 1'b0;
        w_code     = 4'd0;
        w_an_next  = 8'hFF;
        w_ssd_next = 7'h7F;
        if (r_valid) begin
            case (w_sel)
                3'd0: begin w_show = w_nz[0]; w_code = r_digits[3:0];   end
                3'd1: begin w_show = w_nz[1]; w_code = r_digits[7:4];   end
                3'd2: begin w_show = w_nz[2]; w_code = r_digits[11:8];  end
                3'd3: begin w_show = w_nz[3]; w_code = r_digits[15:12]; end
                3'd4: begin w_show = w_nz[4]; w_code = r_digits[19:16]; end
                3'd7: begin w_show = r_flag;  w_code = 4'hF;            end
                default: begin w_show = 1'b0; w_code = 4'd0;            end
            endcase
        end
        if (w_show) begin
            w_an_next  = ~(8'd1 << w_sel);
            w_ssd_next = seg_encode(w_code);
        end
    end

    // Register anodes and segments together so they always switch on the same edge.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_an  <= 8'hFF;
            r_ssd <= 7'h7F;
        end else begin
            r_an  <= w_an_next;
            r_ssd <= w_ssd_next;
        end
    end

    assign Digits = r_digits;
    assign Valid  = r_valid;
    assign Busy   = r_busy;
    assign An     = r_an;
    assign Ssd    = r_ssd;
    assign Dp     = 1'b1;

endmodule

// File: tb/tb_calc_result_display.sv
// Bench for calc_result_display: directed scenarios plus randomized triggers,
// compared against a cycle-level behavioural model and a result scoreboard.

module tb_calc_result_display;

    localparam int RB = 4;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Done;
    logic [15:0] C;
    logic        Flag;
    logic [19:0] Digits;
    logic        Valid;
    logic        Busy;
    logic [7:0]  An;
    logic [6:0]  Ssd;
    logic        Dp;

    calc_result_display #(.REFRESH_BITS(RB)) dut (
        .Clk    (Clk),
        .Reset  (Reset),
        .Done   (Done),
        .C      (C),
        .Flag   (Flag),
        .Digits (Digits),
        .Valid  (Valid),
        .Busy   (Busy),
        .An     (An),
        .Ssd    (Ssd),
        .Dp     (Dp)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int val;
        bit fl;
        int end_cyc;
    } exp_t;

    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    bit started = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg(input int d);
        case (d)
            0: return 7'b0000001;
            1: return 7'b1001111;
            2: return 7'b0010010;
            3: return 7'b0000110;
            4: return 7'b1001100;
            5: return 7'b0100100;
            6: return 7'b0100000;
            7: return 7'b0001111;
            8: return 7'b0000000;
            9: return 7'b0000100;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [19:0] bcd(input int v);
        logic [19:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    // Expected {anode, segments} for a displayed value at scan position sel.
    function automatic logic [14:0] disp(input bit v, input int val, input bit fl, input int sel);
        logic [7:0] an;
        logic [6:0] ssd;
        int p;
        an  = 8'hFF;
        ssd = 7'h7F;
        if (v) begin
            if (sel <= 4) begin
                p = 1;
                for (int i = 0; i < sel; i++) p = p * 10;
                if (sel == 0 || val >= p) begin
                    an  = ~(8'd1 << sel);
                    ssd = seg((val / p) % 10);
                end
            end else if (sel == 7 && fl) begin
                an  = 8'h7F;
                ssd = 7'b0111000;
            end
        end
        return {an, ssd};
    endfunction

    // Behavioural model, advanced once per rising clock edge.
    int           cyc;
    bit           m_doneq, m_conv, m_valid, m_dflag, m_pflag, trig;
    int           m_end, m_dval, m_pval;
    logic [RB-1:0] m_ref;
    logic [7:0]   exp_an;
    logic [6:0]   exp_ssd;
    exp_t         e_push;

    always @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cyc     = 0;
            m_doneq = 1'b0;
            m_conv  = 1'b0;
            m_valid = 1'b0;
            m_dval  = 0;
            m_dflag = 1'b0;
            m_ref   = '0;
            exp_an  = 8'hFF;
            exp_ssd = 7'h7F;
            sb_q.delete();
        end else begin
            {exp_an, exp_ssd} = disp(m_valid, m_dval, m_dflag, int'(m_ref[RB-1 -: 3]));
            m_ref   = m_ref + 1'b1;
            cyc     = cyc + 1;
            trig    = Done && !m_doneq;
            m_doneq = Done;
            if (m_conv) begin
                if (cyc == m_end) begin
                    m_conv  = 1'b0;
                    m_valid = 1'b1;
                    m_dval  = m_pval;
                    m_dflag = m_pflag;
                end
            end else if (trig) begin
                m_conv  = 1'b1;
                m_valid = 1'b0;
                m_pval  = int'(C);
                m_pflag = Flag;
                m_end   = cyc + 16;
                e_push.val     = int'(C);
                e_push.fl      = Flag;
                e_push.end_cyc = cyc + 16;
                sb_q.push_back(e_push);
            end
        end
    end

    // Monitor: compares DUT outputs mid-cycle and retires scoreboard entries on Valid rise.
    bit   v_prev = 1'b0;
    exp_t e_pop;

    always @(negedge Clk) begin
        if (started && !Reset) begin
            check("valid", 32'(Valid), 32'(m_valid));
            check("busy", 32'(Busy), 32'(m_conv));
            check("digits", 32'(Digits), 32'(bcd(m_dval)));
            check("an", 32'(An), 32'(exp_an));
            check("ssd", 32'(Ssd), 32'(exp_ssd));
            check("dp", 32'(Dp), 32'd1);
            if (Valid && !v_prev) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL sb_unexpected: got Digits %0h with no pending conversion", Digits);
                end else begin
                    e_pop = sb_q.pop_front();
                    check("sb_digits", 32'(Digits), 32'(bcd(e_pop.val)));
                    check("sb_latency", cyc, e_pop.end_cyc);
                end
            end
            v_prev = Valid;
        end else begin
            v_prev = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge Clk);
        #1;
    endtask

    task automatic fire(input logic [15:0] val, input logic fl);
        C    = val;
        Flag = fl;
        Done = 1'b1;
        tick(1);
        Done = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        Done  = 1'b0;
        C     = '0;
        Flag  = 1'b0;
        tick(3);
        check("rst_an", 32'(An), 32'hFF);
        check("rst_ssd", 32'(Ssd), 32'h7F);
        check("rst_valid", 32'(Valid), 32'd0);
        check("rst_digits", 32'(Digits), 32'd0);
        Reset   = 1'b0;
        started = 1'b1;
        tick(2);

        fire(16'd0, 1'b0);
        tick(40);
        check("t1_digits", 32'(Digits), 32'h00000);

        fire(16'd65535, 1'b0);
        tick(40);
        check("t2_digits", 32'(Digits), 32'h65535);

        fire(16'd1234, 1'b1);
        tick(40);
        check("t3_digits", 32'(Digits), 32'h01234);

        C    = 16'd500;
        Flag = 1'b0;
        Done = 1'b1;
        tick(5);
        C    = 16'd9;
        Done = 1'b0;
        tick(1);
        Done = 1'b1;
        tick(1);
        Done = 1'b0;
        tick(40);
        check("t4_digits", 32'(Digits), 32'h00500);
        fire(16'd9, 1'b0);
        tick(40);
        check("t4b_digits", 32'(Digits), 32'h00009);

        C    = 16'd4321;
        Done = 1'b1;
        tick(10);
        C    = 16'd777;
        tick(30);
        Done = 1'b0;
        tick(10);
        check("t5_digits", 32'(Digits), 32'h04321);

        fire(16'd321, 1'b0);
        tick(7);
        Reset = 1'b1;
        #1;
        check("t6_an", 32'(An), 32'hFF);
        check("t6_ssd", 32'(Ssd), 32'h7F);
        check("t6_valid", 32'(Valid), 32'd0);
        check("t6_busy", 32'(Busy), 32'd0);
        check("t6_digits", 32'(Digits), 32'd0);
        tick(1);
        Reset = 1'b0;
        tick(2);
        fire(16'd42, 1'b1);
        tick(40);
        check("t6b_digits", 32'(Digits), 32'h00042);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) C = 16'($urandom_range(0, 99));
            else                           C = 16'($urandom_range(0, 65535));
            Flag = 1'($urandom_range(0, 1));
            Done = 1'b1;
            tick($urandom_range(1, 20));
            if ($urandom_range(0, 1) == 1) C = 16'($urandom_range(0, 65535));
            Done = 1'b0;
            tick($urandom_range(0, 30));
        end

        Done = 1'b0;
        tick(40);
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
